input_load_controller: RTL and testbench
========================================

INPUT_LOAD_CONTROLLER -- requirements
Module: input_load_controller

Interface
REQ-001 Parameter numInputs, default 784: pixels per frame; also the shift-register depth.
REQ-002 Parameter pixelWidth, default 8: unsigned grayscale pixel width.
REQ-003 Parameter threshold, default 128: binarisation threshold; a pixel >= threshold maps to bit 1.
REQ-004 clock  input  1  single system clock; every register updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle frame-load request.
REQ-007 abort  input  1  cancels an in-progress load.
REQ-008 pixelData  input  pixelWidth  pixel value.
REQ-009 pixelValid  input  1  pixelData is valid.
REQ-010 pixelReady  output  1  controller accepts a pixel this cycle.
REQ-011 srReset  output  1  clear strobe to the shift register's reset.
REQ-012 serialClock  output  1  shift clock to the shift register.
REQ-013 serialData  output  1  shift data bit to the shift register.
REQ-014 busy  output  1  a frame load is in progress.
REQ-015 frameDone  output  1  one-cycle pulse when a full frame has been shifted.
REQ-016 pixelCount  output  $clog2(numInputs+1)  number of pixels shifted in the current frame.

Function
REQ-017 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.
REQ-018 The state machine SHALL use the states IDLE, CLEAR, WAIT_PIX, SETUP, HIGH and DONE.
REQ-019 IDLE: pixelReady=0, busy=0; start=1 moves to CLEAR; pixelValid is ignored.
REQ-020 CLEAR: lasts 1 cycle with srReset=1 and pixelCount cleared to 0, then moves to WAIT_PIX.
REQ-021 WAIT_PIX: pixelReady=1; on pixelValid&pixelReady, serialData SHALL load (pixelData >= threshold) and the state moves to SETUP; otherwise WAIT_PIX holds indefinitely.
REQ-022 SETUP: serialClock=0, serialData stable; lasts 1 cycle, then moves to HIGH.
REQ-023 HIGH: serialClock=1, serialData unchanged; pixelCount increments; next state is DONE if the incremented count equals numInputs, else WAIT_PIX.
REQ-024 serialData SHALL change only in the cycle entering SETUP, so it is stable 1 cycle before and during each serialClock rising edge.
REQ-025 The minimum per-pixel cost SHALL be 3 cycles; a back-to-back frame SHALL take 1 + 3*numInputs + 1 cycles from the cycle after start until the return to IDLE.
REQ-026 DONE: frameDone=1 for exactly 1 cycle, then move to IDLE; pixelCount holds numInputs until the next CLEAR.
REQ-027 Bit ordering: the first accepted pixel SHALL end at shift-register bit numInputs-1 and the last at bit 0.
REQ-028 busy SHALL be 1 in CLEAR, WAIT_PIX, SETUP and HIGH, and 0 in IDLE and DONE.
REQ-029 start while busy or in DONE SHALL be ignored.
REQ-030 abort in any state other than IDLE SHALL take priority over every other transition: next state IDLE, serialClock=0, pixelReady=0, no frameDone; pixelCount holds its value.
REQ-031 start and abort asserted together in IDLE: abort wins and the state remains IDLE.
REQ-032 pixelReady SHALL be 0 outside WAIT_PIX, and at most one pixel SHALL be accepted per WAIT_PIX visit.
REQ-033 Threshold comparison SHALL be unsigned and full-width; pixelData == threshold yields 1.

Reset
REQ-034 Reset SHALL force, asynchronously: state IDLE, pixelReady=0, srReset=0, serialClock=0, serialData=0, busy=0, frameDone=0, pixelCount=0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no frameDone and no further serialClock edges.
REQ-036 After reset deasserts, the first rising clock edge SHALL be able to accept start.

Verification
REQ-037 Full frame, numInputs=784, pixelValid held 1, pixels alternating 200/50: frameDone appears 2354 cycles after start; the modelled shift register holds ...1010 with bit 783=1; pixelCount=784.
REQ-038 Threshold boundary, pixels 127, 128, 255, 0: serialData sequence 0,1,1,0.
REQ-039 pixelValid stalled 10 cycles mid-frame: serialClock stays 0, pixelReady stays 1, pixelCount is frozen, and the load resumes correctly.
REQ-040 abort during HIGH of pixel 100: serialClock falls the next cycle; state IDLE, busy=0, no frameDone, pixelCount=101.
REQ-041 Reset pulse during WAIT_PIX, then start: srReset pulses, pixelCount restarts at 0, and the full frame completes normally.
REQ-042 start pulsed during busy and during DONE: no effect; exactly one frameDone per frame.

Source files
------------

// File: rtl/input_load_controller.sv
// Frame load controller: accepts pixels over a valid/ready handshake,
// binarises each against a threshold, and bit-bangs the result into an
// external shift register (clear strobe, shift clock, shift data).
//
// Ports:
//   clock, reset     system clock, asynchronous active-high reset
//   start, abort     frame-load request / cancel of an in-progress load
//   pixelData        unsigned grayscale pixel, qualified by pixelValid
//   pixelReady       controller accepts a pixel this cycle
//   srReset          one-cycle clear strobe to the shift register
//   serialClock      shift clock (rising edge shifts)
//   serialData       shift data bit, stable before and during each rising edge
//   busy             frame load in progress
//   frameDone        one-cycle pulse after the last bit is shifted
//   pixelCount       pixels shifted in the current frame
module input_load_controller #(
  parameter int numInputs  = 784,
  parameter int pixelWidth = 8,
  parameter int threshold  = 128
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [pixelWidth-1:0]            pixelData,
  input  logic                             pixelValid,
  output logic                             pixelReady,
  output logic                             srReset,
  output logic                             serialClock,
  output logic                             serialData,
  output logic                             busy,
  output logic                             frameDone,
  output logic [$clog2(numInputs+1)-1:0]   pixelCount
);

  localparam int unsigned CW = $clog2(numInputs + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(numInputs);
  localparam logic [31:0] THRESH = 32'(threshold);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_PIX,
    SETUP,
    HIGH,
    DONE
  } state_t;

  state_t state;
  state_t state_next;
  logic   pixel_bit;

  // Full-width unsigned compare so any threshold value behaves sensibly.
  assign pixel_bit = (32'(pixelData) >= THRESH);

  // Next-state logic; abort overrides every transition outside IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start && !abort) state_next = CLEAR;
      CLEAR:    state_next = WAIT_PIX;
      WAIT_PIX: if (pixelValid) state_next = SETUP;
      SETUP:    state_next = HIGH;
      // pixelCount already holds the incremented value while in HIGH.
      HIGH:     state_next = (pixelCount == LAST_COUNT) ? DONE : WAIT_PIX;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) state_next = IDLE;
  end

  // State and outputs are registered from the next state so every output
  // reflects the state it belongs to, with no input-to-output path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pixelReady  <= 1'b0;
      srReset     <= 1'b0;
      serialClock <= 1'b0;
      serialData  <= 1'b0;
      busy        <= 1'b0;
      frameDone   <= 1'b0;
      pixelCount  <= '0;
    end else begin
      state       <= state_next;
      pixelReady  <= (state_next == WAIT_PIX);
      srReset     <= (state_next == CLEAR);
      serialClock <= (state_next == HIGH);
      frameDone   <= (state_next == DONE);
      busy        <= (state_next == CLEAR) || (state_next == WAIT_PIX) ||
                     (state_next == SETUP) || (state_next == HIGH);
      if (state_next == CLEAR) begin
        pixelCount <= '0;
      end else if (state_next == HIGH) begin
        pixelCount <= pixelCount + CW'(1);
      end
      // Data only moves on the accept edge, one cycle ahead of the shift clock.
      if ((state == WAIT_PIX) && (state_next == SETUP)) begin
        serialData <= pixel_bit;
      end
    end
  end

endmodule

// File: tb/tb_input_load_controller.sv
// Self-checking bench for input_load_controller: pixel driver feeds a
// scoreboard queue of expected bits; a monitor models the shift register and
// checks each shifted bit against the queue.
module tb_input_load_controller;

  localparam int N  = 784;
  localparam int CW = $clog2(N + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [7:0]    pixelData;
  logic          pixelValid;
  logic          pixelReady;
  logic          srReset;
  logic          serialClock;
  logic          serialData;
  logic          busy;
  logic          frameDone;
  logic [CW-1:0] pixelCount;

  input_load_controller #(.numInputs(N), .pixelWidth(8), .threshold(128)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .pixelData(pixelData), .pixelValid(pixelValid), .pixelReady(pixelReady),
    .srReset(srReset), .serialClock(serialClock), .serialData(serialData),
    .busy(busy), .frameDone(frameDone), .pixelCount(pixelCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] pixel;
    logic       bit_exp;
  } vec_t;
  vec_t vecs[8];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int st_cyc = 0;
  int done_cyc = 0;
  int n_done = 0;
  int n_srr = 0;
  logic exp_q[$];
  logic [N-1:0] sr_model = '0;
  logic [N-1:0] exp_sr = '0;
  logic prev_sclk = 1'b0;
  logic prev_sdata = 1'b0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc = cyc + 1;

  // Monitor: shift-register model and scoreboard pop on each shift edge.
  always @(posedge clock) begin
    #1;
    if (srReset) begin
      sr_model = '0;
      n_srr++;
    end
    if (serialClock && !prev_sclk) begin
      check("sdata_stable_before_edge", serialData, prev_sdata);
      check("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("sdata", serialData, exp_q.pop_front());
      sr_model = {sr_model[N-2:0], serialData};
    end
    if (frameDone) begin
      n_done++;
      done_cyc = cyc;
      check("done_one_cycle", prev_done, 0);
    end
    prev_sclk  = serialClock;
    prev_sdata = serialData;
    prev_done  = frameDone;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    exp_sr = '0;
    st_cyc = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    check("clear_srreset", srReset, 1);
    check("clear_busy", busy, 1);
    check("clear_count", pixelCount, 0);
    check("clear_ready", pixelReady, 0);
  endtask

  // Feed n pixels; optional 10-cycle stall before pixel stall_at and a start
  // pulse held while pixel start_at is pending.
  task automatic run_pixels(input int n, input int mode, input int stall_at,
                            input int start_at);
    int idx = 0;
    int guard = 0;
    int stall = 0;
    logic [7:0] p;
    logic b;
    while (idx < n && guard < 4 * n + 100) begin
      if (mode == 1) begin
        p = vecs[idx % 8].pixel;
        b = vecs[idx % 8].bit_exp;
      end else if (mode == 0) begin
        p = (idx % 2 == 0) ? 8'd200 : 8'd50;
        b = (idx % 2 == 0);
      end else begin
        p = 8'($urandom_range(0, 255));
        b = (p >= 8'd128);
      end
      pixelData = p;
      start = (idx == start_at);
      if (idx == stall_at && stall < 10 && (stall > 0 || pixelReady)) begin
        pixelValid = 1'b0;
        stall++;
        check("stall_ready", pixelReady, 1);
        check("stall_sclk", serialClock, 0);
        check("stall_count", pixelCount, stall_at);
      end else begin
        pixelValid = 1'b1;
        if (pixelReady) begin
          exp_q.push_back(b);
          exp_sr = {exp_sr[N-2:0], b};
          idx++;
        end
      end
      step();
      guard++;
    end
    pixelValid = 1'b0;
    start = 1'b0;
    check("feed_budget", idx, n);
  endtask

  task automatic wait_done(input logic poke_start);
    int g = 0;
    while (!frameDone && g < 20) begin
      step();
      g++;
    end
    check("done_seen", frameDone, 1);
    check("done_not_busy", busy, 0);
    check("done_count_full", pixelCount, N);
    start = poke_start;
    step();
    start = 1'b0;
    check("after_done_busy", busy, 0);
    check("after_done_pulse", frameDone, 0);
    check("after_done_count_hold", pixelCount, N);
    step();
    check("start_in_done_ignored", srReset, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    int srr0;
    vecs[0] = '{8'd127, 1'b0};
    vecs[1] = '{8'd128, 1'b1};
    vecs[2] = '{8'd255, 1'b1};
    vecs[3] = '{8'd0,   1'b0};
    vecs[4] = '{8'd129, 1'b1};
    vecs[5] = '{8'd126, 1'b0};
    vecs[6] = '{8'd1,   1'b0};
    vecs[7] = '{8'd200, 1'b1};

    reset = 1'b1; start = 1'b0; abort = 1'b0; pixelData = '0; pixelValid = 1'b0;
    step(); step(); step();
    check("rst_ready", pixelReady, 0);
    check("rst_srreset", srReset, 0);
    check("rst_sclk", serialClock, 0);
    check("rst_sdata", serialData, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frameDone, 0);
    check("rst_count", pixelCount, 0);

    // Frame 1: start on first edge after reset, alternating 200/50, start
    // held during the load and poked during DONE.
    reset = 1'b0;
    do_start();
    run_pixels(N, 0, -1, 3);
    wait_done(1'b1);
    check("f1_latency", done_cyc - st_cyc, 2354);
    check("f1_image", sr_model == exp_sr, 1);
    check("f1_bit783", sr_model[N-1], 1);
    check("f1_low_bits", sr_model[1:0], 2);
    check("f1_done_count", n_done, 1);
    check("f1_srreset_count", n_srr, 1);
    check("f1_queue_empty", exp_q.size(), 0);

    // start and abort together in IDLE: stay idle.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_srreset", srReset, 0);
    step();

    // Frame 2: threshold table, 10-cycle stall before pixel 20.
    do_start();
    run_pixels(N, 1, 20, -1);
    wait_done(1'b0);
    check("f2_latency", done_cyc - st_cyc, 2364);
    check("f2_image", sr_model == exp_sr, 1);
    check("f2_first_four", sr_model[N-1 -: 4], 6);
    check("f2_done_count", n_done, 2);

    // Frame 3: random pixels, abort during HIGH of pixel 100.
    do_start();
    run_pixels(101, 2, -1, -1);
    g = 0;
    while (!serialClock && g < 5) begin
      step();
      g++;
    end
    check("abort_in_high", serialClock, 1);
    check("abort_high_count", pixelCount, 101);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_sclk", serialClock, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", pixelReady, 0);
    check("abort_done", frameDone, 0);
    check("abort_count_hold", pixelCount, 101);
    repeat (5) step();
    check("abort_no_done", n_done, 2);
    check("abort_queue_empty", exp_q.size(), 0);

    // Frame 4: reset pulse during WAIT_PIX, then a full random frame.
    do_start();
    run_pixels(10, 2, -1, -1);
    g = 0;
    while (!pixelReady && g < 5) begin
      step();
      g++;
    end
    check("pre_reset_waitpix", pixelReady, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ready", pixelReady, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_count", pixelCount, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("mid_rst_queue_empty", exp_q.size(), 0);
    srr0 = n_srr;
    do_start();
    run_pixels(N, 2, -1, -1);
    wait_done(1'b0);
    check("f4_latency", done_cyc - st_cyc, 2354);
    check("f4_image", sr_model == exp_sr, 1);
    check("f4_done_count", n_done, 3);
    check("f4_srreset_pulse", n_srr - srr0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
